serial_adder: RTL and testbench

Parametrised bit-serial adder, the sequential successor to the 2-bit combinational board adder. Accepts two WIDTH-bit operands and a carry-in on a start pulse. Runs a single full-adder stage one bit per clock, LSB first, and reports sum, carry-out and signed overflow with a done pulse. Operands come from board switches or an upstream controller; results go to LEDs or a consumer.

---
 rtl/serial_adder.sv | 127 ++++++++++++
 tb/tb_serial_adder.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder stage, LSB first, WIDTH+1 cycles per op.
// Define SERIAL_ADDER_SUB_EN to add the sub port (a-b via ~b and carry-in 1).
module serial_adder #(
  parameter  int WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic             s_bit;
  logic             c_nxt;
  logic             last;
  logic [WIDTH-1:0] b_ld;
  logic             c_ld;

`ifdef SERIAL_ADDER_SUB_EN
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub ? 1'b1 : cin;
`else
  assign b_ld = b;
  assign c_ld = cin;
`endif

  assign s_bit = a_sr_q[0] ^ b_sr_q[0] ^ carry_q;
  assign c_nxt = (a_sr_q[0] & b_sr_q[0])
               | (a_sr_q[0] & carry_q)
               | (b_sr_q[0] & carry_q);
  assign last  = (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    sum_d    = sum_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_RUN;
          a_sr_d  = a;
          b_sr_d  = b_ld;
          carry_d = c_ld;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sum_sr_d = {s_bit, sum_sr_q[WIDTH-1:1]};
        a_sr_d   = {1'b0, a_sr_q[WIDTH-1:1]};
        b_sr_d   = {1'b0, b_sr_q[WIDTH-1:1]};
        carry_d  = c_nxt;
        cnt_d    = cnt_q + CW'(1);
        if (last) begin
          // carry_q is the carry into the MSB on this final bit
          state_d = S_DONE;
          sum_d   = {s_bit, sum_sr_q[WIDTH-1:1]};
          cout_d  = c_nxt;
          ovf_d   = carry_q ^ c_nxt;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      sum_q    <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      sum_q    <= sum_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
    end
  end

  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);
  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=8): latency, boundaries,
// back-to-back starts, mid-run reset, optional subtract mode.
module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a, b;
  logic         cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif
  logic         busy, done, cout, ovf;
  logic [W-1:0] sum;

  int checks = 0;
  int fails  = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one op, scramble operands during RUN, wait (bounded) for done.
  task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                       input logic tc, input logic ts,
                       output int lat, output int nbusy, output int herr);
    logic [W-1:0] s0;
    @(negedge clk);
    a = ta; b = tb_v; cin = tc;
`ifdef SERIAL_ADDER_SUB_EN
    sub = ts;
`else
    if (ts) $display("note: sub request ignored in add-only build");
`endif
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    s0 = sum;
    lat = 0; nbusy = 0; herr = 0;
    while (!done && lat < 40) begin
      if (busy) nbusy++;
      if (sum !== s0) herr++;
      a = W'($urandom); b = W'($urandom); cin = ~cin;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op_chk(input string tag, input logic [W-1:0] ta,
                        input logic [W-1:0] tb_v, input logic tc,
                        input logic ts, input logic [W-1:0] es,
                        input logic ec, input logic eo, input logic tim);
    int lat, nb, he;
    do_op(ta, tb_v, tc, ts, lat, nb, he);
    if (tim) begin
      chk({tag, "_lat"}, lat, W);
      chk({tag, "_busy"}, nb, W);
    end
    chk({tag, "_done"}, done, 1);
    chk({tag, "_hold"}, he, 0);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
  endtask

  initial begin
    int gap;
    logic [W:0] ref_v;
    logic [W-1:0] ra, rb;
    logic rc, ro;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    @(negedge clk); rst_n = 1'b1;

    op_chk("add3_5", 8'd3, 8'd5, 1'b0, 1'b0, 8'd8, 1'b0, 1'b0, 1'b1);
    op_chk("ff_1", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    op_chk("cin_only", 8'h00, 8'h00, 1'b1, 1'b0, 8'h01, 1'b0, 1'b0, 1'b0);
    op_chk("7f_1", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 1'b0);
    op_chk("80_80", 8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    op_chk("ff_ff_c", 8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0);
    @(posedge clk); #1;
    chk("idle_done", done, 0);
    chk("idle_busy", busy, 0);

    // Back-to-back with start held high.
    @(negedge clk);
    a = 8'd10; b = 8'd20; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 8'd30; b = 8'd40;
    gap = 0;
    while (!done && gap < 40) begin @(posedge clk); #1; gap++; end
    chk("b2b1_sum", sum, 8'd30);
    gap = 0;
    @(posedge clk); #1; gap++;
    chk("b2b_no_idle", busy, 1);
    while (!done && gap < 40) begin @(posedge clk); #1; gap++; end
    start = 1'b0;
    chk("b2b_gap", gap, W + 1);
    chk("b2b2_sum", sum, 8'd70);
    @(posedge clk); #1;
    chk("b2b_end_busy", busy, 0);

    // Reset during bit 4 of a run.
    @(negedge clk);
    a = 8'hF0; b = 8'h0F; cin = 1'b1; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_busy", busy, 0);
    chk("mr_done", done, 0);
    chk("mr_sum", sum, 0);
    gap = 0;
    repeat (3) begin @(posedge clk); #1; if (done) gap++; end
    @(negedge clk); rst_n = 1'b1;
    repeat (12) begin @(posedge clk); #1; if (done) gap++; end
    chk("mr_no_done", gap, 0);
    op_chk("post_rst", 8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0, 1'b1);

`ifdef SERIAL_ADDER_SUB_EN
    op_chk("sub5_7", 8'd5, 8'd7, 1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1);
    op_chk("sub80_1", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b0);
    op_chk("sub_cin", 8'd9, 8'd4, 1'b0, 1'b1, 8'd5, 1'b1, 1'b0, 1'b0);
`endif

    // Small sweep against an arithmetic model.
    for (int i = 0; i < 12; i++) begin
      logic ts;
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      ts = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      ts = 1'($urandom);
`endif
      if (ts) begin
        ref_v = {1'b0, ra} + {1'b0, ~rb} + 9'd1;
        ro = (ra[W-1] != rb[W-1]) && (ref_v[W-1] != ra[W-1]);
      end else begin
        ref_v = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
        ro = (ra[W-1] == rb[W-1]) && (ref_v[W-1] != ra[W-1]);
      end
      op_chk($sformatf("rnd%0d", i), ra, rb, rc, ts,
             ref_v[W-1:0], ref_v[W], ro, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
